vram_fetch: RTL and testbench

Memory sequencer that sits directly upstream of the video controller's VRAM ports. On each video fetch request it reads two 16-bit words (four bytes) from the byte-wide shared video/CPU RAM and presents them atomically on `vram_dout1`/`vram_dout2`. CPU accesses are interleaved in idle slots. Video always has priority, so the controller's fixed fetch-to-sample window is met.

---
 rtl/vram_fetch_if.sv | 45 ++++
 rtl/vram_fetch.sv | 192 +++++++++++++++++++
 tb/tb_vram_fetch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_fetch_if.sv
// Bundles the video-fetch, CPU and memory-side buses of the VRAM sequencer.
// The sequencer takes the slave view; the surrounding logic takes the master view.
interface vram_fetch_if #(
    parameter int ADDR_W = 19
);
    logic              vid_req;
    logic [ADDR_W-1:0] vram_addr1;
    logic [ADDR_W-1:0] vram_addr2;
    logic [15:0]       vram_dout1;
    logic [15:0]       vram_dout2;
    logic              vid_done;
    logic              vid_overrun;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport slave (
        input  vid_req, vram_addr1, vram_addr2,
        output vram_dout1, vram_dout2, vid_done, vid_overrun,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output vid_req, vram_addr1, vram_addr2,
        input  vram_dout1, vram_dout2, vid_done, vid_overrun,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/vram_fetch.sv
// VRAM sequencer: four-byte video bursts with priority, CPU byte accesses in idle slots,
// both sharing one byte-wide memory port.
module vram_fetch #(
    parameter int ADDR_W = 19
) (
    input  logic         clk_sys,
    input  logic         reset,
    vram_fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2
    } state_t;

    state_t            state_r;
    logic [1:0]        beat_r;
    logic              pend_r;
    logic [ADDR_W-1:0] pa1_r;
    logic [ADDR_W-1:0] pa2_r;
    logic [ADDR_W-1:0] ba1_r;
    logic [ADDR_W-1:0] ba2_r;
    logic [7:0]        b0_r;
    logic [7:0]        b1_r;
    logic [7:0]        b2_r;
    logic              cpu_served_r;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic [15:0]       dout1_r;
    logic [15:0]       dout2_r;
    logic              vid_done_r;
    logic              vid_overrun_r;
    logic [7:0]        cpu_rdata_r;
    logic              cpu_ack_r;

    logic              pend_v_s;
    logic [ADDR_W-1:0] pa1_s;
    logic [ADDR_W-1:0] pa2_s;
    logic [ADDR_W-1:0] beat_addr_s;

    // A request strobed this cycle counts as pending and supersedes the stored slot.
    always_comb begin
        pend_v_s = pend_r | bus.vid_req;
        if (bus.vid_req) begin
            pa1_s = bus.vram_addr1;
            pa2_s = bus.vram_addr2;
        end else begin
            pa1_s = pa1_r;
            pa2_s = pa2_r;
        end
    end

    // Byte address of the current burst beat; the +1 wraps at the top of VRAM.
    always_comb begin
        beat_addr_s = ba1_r;
        case (beat_r)
            2'd0:    beat_addr_s = ba1_r;
            2'd1:    beat_addr_s = ba1_r + ADDR_W'(1);
            2'd2:    beat_addr_s = ba2_r;
            2'd3:    beat_addr_s = ba2_r + ADDR_W'(1);
            default: beat_addr_s = ba1_r;
        endcase
    end

    // Arbitration FSM, pending video slot, staging bytes and all registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            beat_r        <= 2'd0;
            pend_r        <= 1'b0;
            pa1_r         <= '0;
            pa2_r         <= '0;
            ba1_r         <= '0;
            ba2_r         <= '0;
            b0_r          <= 8'd0;
            b1_r          <= 8'd0;
            b2_r          <= 8'd0;
            cpu_served_r  <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= 8'd0;
            dout1_r       <= 16'd0;
            dout2_r       <= 16'd0;
            vid_done_r    <= 1'b0;
            vid_overrun_r <= 1'b0;
            cpu_rdata_r   <= 8'd0;
            cpu_ack_r     <= 1'b0;
        end else begin
            vid_done_r    <= 1'b0;
            cpu_ack_r     <= 1'b0;
            vid_overrun_r <= bus.vid_req & pend_r;

            if (!bus.cpu_req) begin
                cpu_served_r <= 1'b0;
            end
            if (bus.vid_req) begin
                pend_r <= 1'b1;
                pa1_r  <= bus.vram_addr1;
                pa2_r  <= bus.vram_addr2;
            end

            case (state_r)
                IDLE: begin
                    // Coming from idle the port has already been low, so issue at once.
                    if (pend_v_s) begin
                        state_r    <= VID;
                        beat_r     <= 2'd0;
                        ba1_r      <= pa1_s;
                        ba2_r      <= pa2_s;
                        pend_r     <= 1'b0;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= pa1_s;
                    end else if (bus.cpu_req && !cpu_served_r) begin
                        state_r     <= CPU;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.cpu_we;
                        mem_addr_r  <= bus.cpu_addr;
                        mem_wdata_r <= bus.cpu_wdata;
                    end
                end

                VID: begin
                    if (mem_req_r) begin
                        if (bus.mem_ack) begin
                            mem_req_r <= 1'b0;
                            case (beat_r)
                                2'd0:    b0_r <= bus.mem_rdata;
                                2'd1:    b1_r <= bus.mem_rdata;
                                2'd2:    b2_r <= bus.mem_rdata;
                                default: b2_r <= b2_r;
                            endcase
                            if (beat_r == 2'd3) begin
                                dout1_r    <= {b1_r, b0_r};
                                dout2_r    <= {bus.mem_rdata, b2_r};
                                vid_done_r <= 1'b1;
                                beat_r     <= 2'd0;
                                if (pend_v_s) begin
                                    ba1_r  <= pa1_s;
                                    ba2_r  <= pa2_s;
                                    pend_r <= 1'b0;
                                end else begin
                                    state_r <= IDLE;
                                end
                            end else begin
                                beat_r <= beat_r + 2'd1;
                            end
                        end
                    end else begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= beat_addr_s;
                    end
                end

                CPU: begin
                    // Runs to completion; any video request simply stays pending.
                    if (mem_req_r && bus.mem_ack) begin
                        mem_req_r    <= 1'b0;
                        mem_we_r     <= 1'b0;
                        cpu_ack_r    <= 1'b1;
                        cpu_served_r <= 1'b1;
                        if (!mem_we_r) begin
                            cpu_rdata_r <= bus.mem_rdata;
                        end
                        state_r <= IDLE;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.vram_dout1  = dout1_r;
    assign bus.vram_dout2  = dout2_r;
    assign bus.vid_done    = vid_done_r;
    assign bus.vid_overrun = vid_overrun_r;
    assign bus.cpu_rdata   = cpu_rdata_r;
    assign bus.cpu_ack     = cpu_ack_r;
endmodule

// File: tb/tb_vram_fetch.sv
// Bench for vram_fetch: variable-latency byte memory, directed scenarios, then random
// transactions checked against a flat byte-array view of VRAM.
module tb_vram_fetch;
    localparam int AW  = 19;
    localparam int MSZ = 1 << AW;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    vram_fetch_if #(.ADDR_W(AW)) bus ();
    vram_fetch #(.ADDR_W(AW)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus.slave));

    always #5 clk_sys = ~clk_sys;

    logic [7:0]    phys    [0:MSZ-1];
    logic [7:0]    ref_mem [0:MSZ-1];
    int            lat = 1;
    int            mcnt = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;
    int            ack_cnt = 0;
    int            ovr_cnt = 0;
    int            glitch_cnt = 0;
    logic          prev_req = 1'b0;
    logic [15:0]   pd1 = 16'd0;
    logic [15:0]   pd2 = 16'd0;
    logic [AW-1:0] rd_q [$];

    // Memory model: acknowledges lat cycles after the request is first seen.
    always @(negedge clk_sys) begin
        if (reset) begin
            bus.mem_ack <= 1'b0;
            mcnt        <= 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack <= 1'b0;
            mcnt        <= 0;
        end else if (bus.mem_req) begin
            if (mcnt >= lat) begin
                bus.mem_ack <= 1'b1;
                if (bus.mem_we) phys[bus.mem_addr] <= bus.mem_wdata;
                else bus.mem_rdata <= phys[bus.mem_addr];
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // Event counters, read-address log and dout stability watch.
    always @(negedge clk_sys) begin
        if (bus.vid_done)    done_cnt <= done_cnt + 1;
        if (bus.cpu_ack)     ack_cnt  <= ack_cnt + 1;
        if (bus.vid_overrun) ovr_cnt  <= ovr_cnt + 1;
        if (bus.mem_req && !prev_req && !bus.mem_we) rd_q.push_back(bus.mem_addr);
        prev_req <= bus.mem_req;
        if (!reset && !bus.vid_done && (bus.vram_dout1 !== pd1 || bus.vram_dout2 !== pd2))
            glitch_cnt <= glitch_cnt + 1;
        pd1 <= bus.vram_dout1;
        pd2 <= bus.vram_dout2;
    end

    function automatic logic [15:0] exp_word(input logic [AW-1:0] a);
        int nxt;
        nxt = (int'(a) + 1) % MSZ;
        return {ref_mem[nxt], ref_mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Issues a video strobe and/or a held CPU request in the same cycle (cycle 0) and
    // waits for the completions, returning the cycle each one was seen (-1 if never).
    task automatic run_txn(input bit dv, input bit dc, input bit we,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [AW-1:0] ca, input logic [7:0] cd,
                           output int dcyc, output int acyc);
        dcyc = -1;
        acyc = -1;
        bus.vid_req    = dv;
        bus.vram_addr1 = a1;
        bus.vram_addr2 = a2;
        bus.cpu_req    = dc;
        bus.cpu_we     = we;
        bus.cpu_addr   = ca;
        bus.cpu_wdata  = cd;
        for (int c = 1; c <= 300; c++) begin
            tick();
            bus.vid_req = 1'b0;
            if (acyc >= 0) bus.cpu_req = 1'b0;
            if (dcyc < 0 && bus.vid_done === 1'b1) dcyc = c;
            if (acyc < 0 && bus.cpu_ack === 1'b1) acyc = c;
            if ((!dv || dcyc >= 0) && (!dc || acyc >= 0)) break;
        end
        check("txn_timeout", {31'd0, ((dv && dcyc < 0) || (dc && acyc < 0))}, 32'd0);
        tick();
        bus.cpu_req = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int dcyc, acyc, a0, d0, o0, cyc;
        logic [AW-1:0] a1, a2, ca;
        logic [7:0] cd;
        logic [15:0] e1, e2;
        logic [7:0] er;
        bit dv, dc, we;

        for (int i = 0; i < MSZ; i++) begin
            phys[i]    = 8'(i);
            ref_mem[i] = 8'(i);
        end
        bus.vid_req = 1'b0; bus.vram_addr1 = '0; bus.vram_addr2 = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 8'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'd0;

        // Reset state
        repeat (2) tick();
        check("rst_dout1", 32'(bus.vram_dout1), 32'd0);
        check("rst_dout2", 32'(bus.vram_dout2), 32'd0);
        check("rst_flags", {26'd0, bus.vid_done, bus.vid_overrun, bus.cpu_ack, bus.mem_req,
                            bus.mem_we, 1'b0}, 32'd0);
        check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        reset = 1'b0;
        tick();

        // Basic fetch, 1-cycle memory
        run_txn(1'b1, 1'b0, 1'b0, 19'h00100, 19'h06010, '0, 8'd0, dcyc, acyc);
        check("basic_latency", 32'(dcyc), 32'd12);
        check("basic_dout1", 32'(bus.vram_dout1), 32'(exp_word(19'h00100)));
        check("basic_dout2", 32'(bus.vram_dout2), 32'(exp_word(19'h06010)));

        // Address wrap at the top of VRAM
        rd_q.delete();
        run_txn(1'b1, 1'b0, 1'b0, 19'h7FFFF, 19'h12345, '0, 8'd0, dcyc, acyc);
        check("wrap_reads", 32'(rd_q.size()), 32'd4);
        if (rd_q.size() >= 2) check("wrap_beat1_addr", 32'(rd_q[1]), 32'd0);
        check("wrap_dout1", 32'(bus.vram_dout1), 32'(exp_word(19'h7FFFF)));

        // Simultaneous CPU read and video request: video first
        a0 = ack_cnt;
        run_txn(1'b1, 1'b1, 1'b0, 19'h00200, 19'h00300, 19'h04321, 8'd0, dcyc, acyc);
        check("prio_order", {31'd0, (acyc > dcyc)}, 32'd1);
        check("prio_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[19'h04321]));
        check("prio_ack_once", 32'(ack_cnt - a0), 32'd1);

        // CPU write in flight (3-cycle memory), then a video request
        lat = 3;
        ca = 19'h01234; cd = 8'hA5;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        d0 = done_cnt;
        repeat (2) tick();
        ref_mem[ca] = cd;
        run_txn(1'b1, 1'b1, 1'b1, ca, 19'h01233, ca, cd, dcyc, acyc);
        check("wr_first", {31'd0, (acyc >= 0 && acyc < dcyc)}, 32'd1);
        check("wr_mem", 32'(phys[ca]), 32'(cd));
        check("wr_dout1", 32'(bus.vram_dout1), 32'(exp_word(ca)));
        check("wr_dout2", 32'(bus.vram_dout2), 32'(exp_word(19'h01233)));
        check("wr_one_burst", 32'(done_cnt - d0), 32'd1);

        // Two requests during one burst
        lat = 1;
        o0 = ovr_cnt; d0 = done_cnt;
        bus.vid_req = 1'b1; bus.vram_addr1 = 19'h00400; bus.vram_addr2 = 19'h00500;
        tick(); bus.vid_req = 1'b0;
        repeat (2) tick();
        bus.vid_req = 1'b1; bus.vram_addr1 = 19'h00600; bus.vram_addr2 = 19'h00700;
        tick(); bus.vid_req = 1'b0;
        repeat (2) tick();
        bus.vid_req = 1'b1; bus.vram_addr1 = 19'h00800; bus.vram_addr2 = 19'h00900;
        tick(); bus.vid_req = 1'b0;
        cyc = 0;
        while (done_cnt - d0 < 1 && cyc < 200) begin tick(); cyc++; end
        check("ovr_first_dout1", 32'(bus.vram_dout1), 32'(exp_word(19'h00400)));
        while (done_cnt - d0 < 2 && cyc < 200) begin tick(); cyc++; end
        check("ovr_second_dout1", 32'(bus.vram_dout1), 32'(exp_word(19'h00800)));
        check("ovr_second_dout2", 32'(bus.vram_dout2), 32'(exp_word(19'h00900)));
        repeat (20) tick();
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_bursts", 32'(done_cnt - d0), 32'd2);

        // Reset during beat 2
        rd_q.delete();
        bus.vid_req = 1'b1; bus.vram_addr1 = 19'h00A00; bus.vram_addr2 = 19'h00B00;
        tick(); bus.vid_req = 1'b0;
        cyc = 0;
        while (rd_q.size() < 3 && cyc < 100) begin tick(); cyc++; end
        check("rst_mid_reached", 32'(rd_q.size()), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_memreq", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mid_dout", {bus.vram_dout1, bus.vram_dout2}, 32'd0);
        check("rst_mid_flags", {28'd0, bus.vid_done, bus.vid_overrun, bus.cpu_ack,
                                bus.mem_we}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        run_txn(1'b1, 1'b0, 1'b0, 19'h00C00, 19'h3FFFF, '0, 8'd0, dcyc, acyc);
        check("after_rst_latency", 32'(dcyc), 32'd12);
        check("after_rst_dout1", 32'(bus.vram_dout1), 32'(exp_word(19'h00C00)));
        check("after_rst_dout2", 32'(bus.vram_dout2), 32'(exp_word(19'h3FFFF)));

        // Random transactions
        for (int n = 0; n < 24; n++) begin
            lat = int'($urandom_range(1, 4));
            dv  = 1'($urandom_range(0, 1));
            dc  = 1'($urandom_range(0, 1));
            if (!dv && !dc) dv = 1'b1;
            we  = 1'($urandom_range(0, 1));
            a1  = AW'($urandom);
            a2  = AW'($urandom);
            ca  = AW'($urandom);
            cd  = 8'($urandom);
            e1  = exp_word(a1);
            e2  = exp_word(a2);
            er  = ref_mem[ca];
            a0  = ack_cnt;
            run_txn(dv, dc, we, a1, a2, ca, cd, dcyc, acyc);
            if (dc && we) ref_mem[ca] = cd;
            if (dv) begin
                check("rnd_latency", 32'(dcyc), 32'(4 * lat + 8));
                check("rnd_dout1", 32'(bus.vram_dout1), 32'(e1));
                check("rnd_dout2", 32'(bus.vram_dout2), 32'(e2));
            end
            if (dc && !we) check("rnd_rdata", 32'(bus.cpu_rdata), 32'(er));
            if (dc && we) check("rnd_wmem", 32'(phys[ca]), 32'(cd));
            check("rnd_acks", 32'(ack_cnt - a0), 32'(dc));
        end

        check("dout_stable", 32'(glitch_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
